// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V control FSM (fetch/decode/exec/mem/wb) with registered control outputs
module multicycle_ctrl #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             imem_valid,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_w,
  output logic             pc_w,
  output logic             reg_w,
  output logic [1:0]       pc_sel,
  output logic             alu_src,
  output logic             mem2reg,
  output logic             word_op,
  output logic [1:0]       alu_op,
  output logic             halt,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] LIM = TW'(MEM_TIMEOUT - 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [1:0] pc_sel_q, pc_sel_d, alu_op_q, alu_op_d;
  logic alu_src_q, alu_src_d, mem2reg_q, mem2reg_d, word_op_q, word_op_d;
  logic imem_req_q, dmem_req_q, dmem_we_q, ir_w_q, pc_w_q, reg_w_q, halt_q, trap_q;
  logic [6:0] op;
  logic is_ld, is_st, is_opi, is_op, is_lui, is_aui, is_jal, is_jalr, is_br, is_w, legal, ebreak, done;
  assign op      = ir_q[6:0];
  assign is_ld   = op == 7'b0000011;
  assign is_st   = op == 7'b0100011;
  assign is_opi  = op == 7'b0010011;
  assign is_op   = op == 7'b0110011;
  assign is_lui  = op == 7'b0110111;
  assign is_aui  = op == 7'b0010111;
  assign is_jal  = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_br   = op == 7'b1100011;
  assign is_w    = op == 7'b0011011 || op == 7'b0111011;
  assign ebreak  = ir_q == 32'h0010_0073;
  assign legal   = is_ld || is_st || is_opi || is_op || is_lui || is_aui || is_jal || is_jalr || is_br
                   || (is_w && XLEN == 64);
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_sel_d  = pc_sel_q;
    alu_src_d = alu_src_q;
    mem2reg_d = mem2reg_q;
    word_op_d = word_op_q;
    alu_op_d  = alu_op_q;
    cnt_d     = (state_q == MEM && !dmem_ready) ? cnt_q + 1'b1 : '0;
    case (state_q)
      FETCH: if (imem_valid) begin
        state_d = DECODE;
        ir_d    = instr;
      end
      DECODE: begin
        state_d   = ebreak ? HALT : legal ? EXEC : TRAP;
        alu_src_d = !(is_op || op == 7'b0111011 || is_br);
        mem2reg_d = is_ld;
        word_op_d = is_w;
        alu_op_d  = is_br ? 2'b01 : (is_opi || is_op || is_w) ? 2'b10 : 2'b00;
      end
      EXEC: begin
        state_d  = (is_ld || is_st) ? MEM : WB;
        pc_sel_d = is_jalr ? 2'b10 : (is_jal || (is_br && branch_taken)) ? 2'b01 : 2'b00;
      end
      MEM: state_d = dmem_ready ? (is_st ? FETCH : WB) : (cnt_q == LIM) ? TRAP : MEM;
      WB: state_d = FETCH;
      default: state_d = state_q;
    endcase
    // a store retires straight out of MEM; everything else retires in WB
    done  = state_d == WB || (state_q == MEM && state_d == FETCH);
    ret_d = done ? ret_q + 1'b1 : ret_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      cnt_q      <= '0;
      ret_q      <= '0;
      pc_sel_q   <= '0;
      alu_op_q   <= '0;
      alu_src_q  <= 1'b0;
      mem2reg_q  <= 1'b0;
      word_op_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      ir_w_q     <= 1'b0;
      pc_w_q     <= 1'b0;
      reg_w_q    <= 1'b0;
      halt_q     <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      ret_q      <= ret_d;
      pc_sel_q   <= pc_sel_d;
      alu_op_q   <= alu_op_d;
      alu_src_q  <= alu_src_d;
      mem2reg_q  <= mem2reg_d;
      word_op_q  <= word_op_d;
      imem_req_q <= state_d == FETCH;
      dmem_req_q <= state_d == MEM;
      dmem_we_q  <= state_d == MEM && is_st;
      ir_w_q     <= state_q == FETCH && imem_valid;
      pc_w_q     <= done;
      reg_w_q    <= state_d == WB && !is_br;
      halt_q     <= state_d == HALT;
      trap_q     <= state_d == TRAP;
    end
  end
  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign ir_w     = ir_w_q;
  assign pc_w     = pc_w_q;
  assign reg_w    = reg_w_q;
  assign pc_sel   = pc_sel_q;
  assign alu_src  = alu_src_q;
  assign mem2reg  = mem2reg_q;
  assign word_op  = word_op_q;
  assign alu_op   = alu_op_q;
  assign halt     = halt_q;
  assign trap     = trap_q;
  assign retired  = ret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl; a 64-bit/32-bit-counter instance and a 32-bit/4-bit-counter instance share stimulus
module tb_multicycle_ctrl;
  typedef struct {
    logic [31:0] instr;
    logic        taken;
    int          wait_c;
    logic [1:0]  kind;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        word_op;
    logic        mem2reg;
    logic [1:0]  pc_sel;
    logic        reg_w;
    int          dcyc;
    logic        we;
    int          ret;
  } vec_t;
  logic clk, rst_n, imem_valid, dmem_ready, branch_taken;
  logic [31:0] instr;
  logic imem_req, dmem_req, dmem_we, ir_w, pc_w, reg_w, alu_src, mem2reg, word_op, halt, trap;
  logic [1:0] pc_sel, alu_op;
  logic [31:0] retired;
  logic b_imem_req, b_dmem_req, b_dmem_we, b_ir_w, b_pc_w, b_reg_w, b_alu_src, b_mem2reg, b_word_op, b_halt, b_trap;
  logic [1:0] b_pc_sel, b_alu_op;
  logic [3:0] b_retired;
  logic [14:0] o64, o32;
  int checks, errors, events, mret, dcyc;
  logic we_s, pul, tp, hp;
  vec_t q[$];
  vec_t tbl[10];
  vec_t e;
  assign o64 = {imem_req, dmem_req, dmem_we, ir_w, pc_w, reg_w, pc_sel, alu_src, mem2reg, word_op, alu_op, halt, trap};
  assign o32 = {b_imem_req, b_dmem_req, b_dmem_we, b_ir_w, b_pc_w, b_reg_w, b_pc_sel, b_alu_src, b_mem2reg,
                b_word_op, b_alu_op, b_halt, b_trap};
  multicycle_ctrl #(.XLEN(64), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_w(ir_w),
    .pc_w(pc_w), .reg_w(reg_w), .pc_sel(pc_sel), .alu_src(alu_src), .mem2reg(mem2reg), .word_op(word_op),
    .alu_op(alu_op), .halt(halt), .trap(trap), .retired(retired));
  multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(b_imem_req), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
    .ir_w(b_ir_w), .pc_w(b_pc_w), .reg_w(b_reg_w), .pc_sel(b_pc_sel), .alu_src(b_alu_src), .mem2reg(b_mem2reg),
    .word_op(b_word_op), .alu_op(b_alu_op), .halt(b_halt), .trap(b_trap), .retired(b_retired));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, a, x);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [31:0] i, input logic t, input int w, input logic [1:0] k,
                              input logic as, input logic [1:0] ao, input logic wo, input logic m2r,
                              input logic [1:0] ps, input logic rw, input int dc, input logic we);
    vec_t v;
    v.instr = i; v.taken = t; v.wait_c = w; v.kind = k; v.alu_src = as; v.alu_op = ao; v.word_op = wo;
    v.mem2reg = m2r; v.pc_sel = ps; v.reg_w = rw; v.dcyc = dc; v.we = we; v.ret = 0;
    return v;
  endfunction
  task automatic push(input vec_t v);
    if (v.kind == 2'd0) mret++;
    v.ret = mret;
    q.push_back(v);
  endtask
  task automatic run(input vec_t v);
    int n, k, ev0;
    n = 0;
    while (!imem_req && n < 50) begin cyc(); n++; end
    if (!imem_req) begin
      checks++; errors++;
      $display("FAIL fetch_wait: imem_req=0 want 1");
      return;
    end
    push(v);
    ev0 = events;
    instr = v.instr; imem_valid = 1'b1; branch_taken = v.taken;
    cyc();
    imem_valid = 1'b0; instr = 32'h0;
    k = 0; n = 0;
    while (events == ev0 && n < 60) begin
      dmem_ready = dmem_req && (k == v.wait_c);
      if (dmem_req) k++;
      cyc();
      n++;
    end
    dmem_ready = 1'b0;
    if (events == ev0) begin
      checks++; errors++;
      $display("FAIL done_wait: no completion for instr %h", v.instr);
    end
  endtask
  // scoreboard: pop one expected record per retirement, halt or trap
  always @(negedge clk) begin
    if (!rst_n) begin
      dcyc = 0; we_s = 1'b0; pul = 1'b0; tp = 1'b0; hp = 1'b0;
    end else begin
      chk("pulse_excl", {31'd0, !(ir_w && (pc_w || reg_w)) && !(reg_w && !pc_w)}, 1);
      if (ir_w) begin dcyc = 0; we_s = 1'b0; pul = 1'b0; end
      if (dmem_req) dcyc++;
      if (dmem_we) we_s = 1'b1;
      if (pc_w || (trap && !tp) || (halt && !hp)) begin
        events++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: unexpected completion, pc_w=%0b halt=%0b trap=%0b", pc_w, halt, trap);
        end else begin
          e = q.pop_front();
          chk("end_kind", pc_w ? 0 : halt ? 1 : 2, {30'd0, e.kind});
          chk("retired", retired, e.ret);
          chk("dmem_cycles", dcyc, e.dcyc);
          chk("dmem_we", {31'd0, we_s}, {31'd0, e.we});
          if (e.kind == 2'd0) begin
            chk("alu_src", {31'd0, alu_src}, {31'd0, e.alu_src});
            chk("alu_op", {30'd0, alu_op}, {30'd0, e.alu_op});
            chk("word_op", {31'd0, word_op}, {31'd0, e.word_op});
            chk("mem2reg", {31'd0, mem2reg}, {31'd0, e.mem2reg});
            chk("pc_sel", {30'd0, pc_sel}, {30'd0, e.pc_sel});
            chk("reg_w", {31'd0, reg_w}, {31'd0, e.reg_w});
          end else chk("no_pulse", {31'd0, pul}, 0);
        end
      end
      if (pc_w || reg_w) pul = 1'b1;
      tp = trap;
      hp = halt;
    end
  end
  initial begin
    checks = 0; errors = 0; events = 0; mret = 0;
    rst_n = 1'b1; instr = 32'h0; imem_valid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    tbl[0] = mk(32'h0050_0093, 0, -1, 0, 1, 2'b10, 0, 0, 2'b00, 1, 0, 0);
    tbl[1] = mk(32'h0000_B103, 0, 3, 0, 1, 2'b00, 0, 1, 2'b00, 1, 4, 0);
    tbl[2] = mk(32'h0020_81B3, 0, -1, 0, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0);
    tbl[3] = mk(32'h0020_8463, 1, -1, 0, 0, 2'b01, 0, 0, 2'b01, 0, 0, 0);
    tbl[4] = mk(32'h0020_8463, 0, -1, 0, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0);
    tbl[5] = mk(32'h0080_00EF, 0, -1, 0, 1, 2'b00, 0, 0, 2'b01, 1, 0, 0);
    tbl[6] = mk(32'h0000_80E7, 0, -1, 0, 1, 2'b00, 0, 0, 2'b10, 1, 0, 0);
    tbl[7] = mk(32'h0000_10B7, 0, -1, 0, 1, 2'b00, 0, 0, 2'b00, 1, 0, 0);
    tbl[8] = mk(32'h0020_B023, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 1, 1);
    tbl[9] = mk(32'h0000_B103, 0, 15, 0, 1, 2'b00, 0, 1, 2'b00, 1, 16, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out", {17'd0, o64}, 0);
    chk("rst_async_ret", retired, 0);
    chk("rst_async_out32", {17'd0, o32}, 0);
    cyc(); cyc();
    chk("rst_held_out", {17'd0, o64}, 0);
    rst_n = 1'b1;
    // ADDI presented in the very first cycle after release
    push(tbl[0]);
    instr = tbl[0].instr; imem_valid = 1'b1;
    cyc();
    imem_valid = 1'b0; instr = 32'h0;
    chk("addi_ir_w", {31'd0, ir_w}, 1);
    chk("addi_imem_req_dec", {31'd0, imem_req}, 0);
    cyc();
    chk("addi_exec_pulses", {29'd0, ir_w, pc_w, reg_w}, 0);
    chk("addi_ctrl", {29'd0, alu_src, alu_op}, 3'b110);
    cyc();
    chk("addi_wb_pulses", {30'd0, pc_w, reg_w}, 2'b11);
    chk("addi_retired", retired, 1);
    foreach (tbl[i]) run(tbl[i]);
    while (mret < 17) run(tbl[0]);
    chk("cnt4_wrap", {28'd0, b_retired}, 32'(mret % 16));
    chk("cnt32_total", retired, 17);
    run(mk(32'h0010_009B, 0, -1, 0, 1, 2'b10, 1, 0, 2'b00, 1, 0, 0));
    chk("w32_trap", {31'd0, b_trap}, 1);
    chk("w32_imem_req", {31'd0, b_imem_req}, 0);
    chk("w32_retired", {28'd0, b_retired}, 1);
    run(mk(32'h0020_B023, 0, -1, 2, 1, 2'b00, 0, 0, 2'b00, 0, 16, 1));
    imem_valid = 1'b1; instr = tbl[0].instr;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("trap_absorb", {26'd0, trap, imem_req, dmem_req, ir_w, pc_w, reg_w}, 32'h20);
    end
    imem_valid = 1'b0;
    chk("trap_ret_hold", retired, mret);
    rst_n = 1'b0;
    #1;
    chk("rst_trap_out", {17'd0, o64}, 0);
    chk("rst_trap_ret", retired, 0);
    chk("sb_drained", q.size(), 0);
    mret = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_imem_req", {31'd0, imem_req}, 1);
    run(mk(32'h0010_0073, 0, -1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    imem_valid = 1'b1; instr = tbl[0].instr;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_absorb", {28'd0, halt, imem_req, ir_w, trap}, 32'h8);
    end
    imem_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    instr = tbl[1].instr; imem_valid = 1'b1;
    cyc();
    imem_valid = 1'b0;
    for (int n = 0; n < 10 && !dmem_req; n++) cyc();
    chk("ld_in_mem", {31'd0, dmem_req}, 1);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ld_req", {31'd0, dmem_req}, 0);
    chk("rst_mid_ld_out", {17'd0, o64}, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel2_imem_req", {31'd0, imem_req}, 1);
    chk("sb_final", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
